// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator keypad-entry controller.
package calc_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    S_N1    = 3'd0,
    S_OP    = 3'd1,
    S_N2    = 3'd2,
    S_CHAIN = 3'd3,
    S_CALC  = 3'd4,
    S_RES   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/calc_operand_reg.sv
// BCD operand shift register with saturating digit count, load and clear.
// Backspace support is built only when CALC_BACKSPACE_EN is defined.
module calc_operand_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      shift,
  input  logic                      load_digit,
  input  logic                      load_word,
  input  logic                      bs,
  input  logic [BCD_W-1:0]          digit,
  input  logic [BCD_W*DIGITS-1:0]   word,
  output logic [BCD_W*DIGITS-1:0]   value
);

  localparam int DATA_W = BCD_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

  logic [CW-1:0] cnt_q;

  // Leading zeros leave the count at 0 so they never consume a digit slot.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      value <= '0;
      cnt_q <= '0;
    end else if (load_word) begin
      value <= word;
      cnt_q <= '0;
    end else if (load_digit) begin
      value <= DATA_W'(digit);
      cnt_q <= (digit != '0) ? CW'(1) : '0;
    end else if (shift && (cnt_q < MAX_CNT)) begin
      value <= {value[DATA_W-BCD_W-1:0], digit};
      if ((cnt_q != '0) || (digit != '0)) cnt_q <= cnt_q + CW'(1);
    end
`ifdef CALC_BACKSPACE_EN
    else if (bs && (cnt_q != '0)) begin
      value <= value >> BCD_W;
      cnt_q <= cnt_q - CW'(1);
    end
`endif
  end

`ifndef CALC_BACKSPACE_EN
  logic unused_bs;
  assign unused_bs = bs;
`endif

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-entry FSM: collects BCD operands, drives the ALU req/ack handshake
// and selects the display value. Optional backspace: define CALC_BACKSPACE_EN.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OP_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic                    key_is_num,
  input  logic                    key_is_op,
  input  logic                    key_is_eq,
  input  logic                    key_is_clr,
  input  logic                    key_is_bs,
  input  logic [3:0]              key_num,
  input  logic [OP_W-1:0]         key_op,
  output logic                    alu_req,
  input  logic                    alu_ack,
  input  logic                    alu_err,
  input  logic [BCD_W*DIGITS-1:0] alu_result,
  output logic [BCD_W*DIGITS-1:0] num1,
  output logic [BCD_W*DIGITS-1:0] num2,
  output logic [OP_W-1:0]         operation,
  output logic [BCD_W*DIGITS-1:0] disp_val,
  output logic                    error,
  output logic [2:0]              state
);

  state_t state_q, state_d;
  logic [OP_W-1:0] op_d, pend_q, pend_d;
  logic k_clr, k_eq, k_op, k_num, k_bs;
  logic n1_shift, n1_ld_dig, n1_ld_word, n1_bs;
  logic n2_shift, n2_ld_dig, n2_clr, n2_bs;

  // Key class priority: clr > eq > op > num > bs.
  assign k_clr = key_valid & key_is_clr;
  assign k_eq  = key_valid & ~key_is_clr & key_is_eq;
  assign k_op  = key_valid & ~key_is_clr & ~key_is_eq & key_is_op;
  assign k_num = key_valid & ~key_is_clr & ~key_is_eq & ~key_is_op & key_is_num & (key_num <= 4'd9);
`ifdef CALC_BACKSPACE_EN
  assign k_bs  = key_valid & ~key_is_clr & ~key_is_eq & ~key_is_op & ~key_is_num & key_is_bs;
`else
  assign k_bs  = 1'b0;
  logic unused_bs;
  assign unused_bs = key_is_bs;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_N1;
      operation <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      operation <= op_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = operation;
    pend_d     = pend_q;
    n1_shift   = 1'b0;
    n1_ld_dig  = 1'b0;
    n1_ld_word = 1'b0;
    n1_bs      = 1'b0;
    n2_shift   = 1'b0;
    n2_ld_dig  = 1'b0;
    n2_clr     = 1'b0;
    n2_bs      = 1'b0;
    if (k_clr) begin
      state_d = S_N1;
      op_d    = '0;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        S_N1: begin
          if (k_op) begin
            op_d    = key_op;
            state_d = S_OP;
          end else if (k_num) n1_shift = 1'b1;
          else if (k_bs) n1_bs = 1'b1;
        end
        S_OP: begin
          if (k_op) op_d = key_op;
          else if (k_num) begin
            n2_ld_dig = 1'b1;
            state_d   = S_N2;
          end
        end
        S_N2: begin
          if (k_eq) state_d = S_CALC;
          else if (k_op) begin
            pend_d  = key_op;
            state_d = S_CHAIN;
          end else if (k_num) n2_shift = 1'b1;
          else if (k_bs) n2_bs = 1'b1;
        end
        // Operands are held while waiting; only the ack can move on.
        S_CHAIN: begin
          if (alu_ack) begin
            if (alu_err) state_d = S_ERR;
            else begin
              n1_ld_word = 1'b1;
              n2_clr     = 1'b1;
              op_d       = pend_q;
              state_d    = S_OP;
            end
          end
        end
        S_CALC: begin
          if (alu_ack) begin
            if (alu_err) state_d = S_ERR;
            else begin
              n1_ld_word = 1'b1;
              state_d    = S_RES;
            end
          end
        end
        S_RES: begin
          if (k_eq) state_d = S_CALC;
          else if (k_op) begin
            op_d    = key_op;
            state_d = S_OP;
          end else if (k_num) begin
            n1_ld_dig = 1'b1;
            n2_clr    = 1'b1;
            state_d   = S_N1;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_N1;
      endcase
    end
  end

  calc_operand_reg #(.DIGITS(DIGITS)) u_num1 (
    .clk(clk), .reset(reset), .clr(k_clr),
    .shift(n1_shift), .load_digit(n1_ld_dig), .load_word(n1_ld_word), .bs(n1_bs),
    .digit(key_num), .word(alu_result), .value(num1)
  );

  calc_operand_reg #(.DIGITS(DIGITS)) u_num2 (
    .clk(clk), .reset(reset), .clr(k_clr | n2_clr),
    .shift(n2_shift), .load_digit(n2_ld_dig), .load_word(1'b0), .bs(n2_bs),
    .digit(key_num), .word(alu_result), .value(num2)
  );

  assign alu_req  = (state_q == S_CHAIN) || (state_q == S_CALC);
  assign error    = (state_q == S_ERR);
  assign state    = state_q;
  assign disp_val = (state_q == S_N2) ? num2 : num1;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed self-checking bench for calc_entry_ctrl (default build, 4 digits).
module tb_calc_entry_ctrl;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, key_valid, key_is_num, key_is_op, key_is_eq, key_is_clr, key_is_bs;
  logic [3:0]  key_num;
  logic [1:0]  key_op;
  logic        alu_req, alu_ack, alu_err, error;
  logic [15:0] alu_result, num1, num2, disp_val;
  logic [1:0]  operation;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  calc_entry_ctrl #(.DIGITS(4), .OP_W(2)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_is_num(key_is_num),
    .key_is_op(key_is_op), .key_is_eq(key_is_eq), .key_is_clr(key_is_clr),
    .key_is_bs(key_is_bs), .key_num(key_num), .key_op(key_op), .alu_req(alu_req),
    .alu_ack(alu_ack), .alu_err(alu_err), .alu_result(alu_result), .num1(num1),
    .num2(num2), .operation(operation), .disp_val(disp_val), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  // One-cycle key strobe; returns at the negedge after the acting posedge.
  task automatic key(input logic n, input logic o, input logic e, input logic c,
                     input logic [3:0] d, input logic [1:0] op);
    @(negedge clk);
    key_valid = 1'b1; key_is_num = n; key_is_op = o; key_is_eq = e; key_is_clr = c;
    key_num = d; key_op = op;
    @(negedge clk);
    key_valid = 1'b0; key_is_num = 1'b0; key_is_op = 1'b0; key_is_eq = 1'b0;
    key_is_clr = 1'b0; key_num = 4'd0; key_op = 2'd0;
  endtask

  task automatic dig(input logic [3:0] d);   key(1'b1, 1'b0, 1'b0, 1'b0, d, 2'd0);  endtask
  task automatic opk(input logic [1:0] o);   key(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, o); endtask
  task automatic eqk();                      key(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0); endtask
  task automatic clrk();                     key(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0); endtask

  task automatic ack(input logic [15:0] res, input logic err);
    @(negedge clk);
    alu_ack = 1'b1; alu_err = err; alu_result = res;
    @(negedge clk);
    alu_ack = 1'b0; alu_err = 1'b0; alu_result = 16'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state); end
    vectors++; if (num1 !== 16'h0 || num2 !== 16'h0) begin miscompares++; $display("FAIL reset_nums got %h/%h want 0/0", num1, num2); end
    vectors++; if (operation !== 2'd0 || alu_req !== 1'b0 || error !== 1'b0) begin miscompares++; $display("FAIL reset_ctrl got op=%0d req=%b err=%b want 0/0/0", operation, alu_req, error); end
  endtask

  task automatic test_basic_calc();
    dig(4'd1); dig(4'd2);
    vectors++; if (num1 !== 16'h0012) begin miscompares++; $display("FAIL basic_num1 got %h want 0012", num1); end
    opk(OP_ADD); dig(4'd3);
    vectors++; if (state !== 3'd2 || disp_val !== 16'h0003 || alu_req !== 1'b0) begin miscompares++; $display("FAIL basic_n2 got st=%0d disp=%h req=%b want 2/0003/0", state, disp_val, alu_req); end
    eqk();
    vectors++; if (state !== 3'd4 || alu_req !== 1'b1) begin miscompares++; $display("FAIL basic_calc got st=%0d req=%b want 4/1", state, alu_req); end
    ack(16'h0015, 1'b0);
    vectors++; if (num1 !== 16'h0015 || state !== 3'd5 || disp_val !== 16'h0015 || alu_req !== 1'b0) begin miscompares++; $display("FAIL basic_res got n1=%h st=%0d disp=%h req=%b want 0015/5/0015/0", num1, state, disp_val, alu_req); end
    vectors++; if (num2 !== 16'h0003 || operation !== OP_ADD) begin miscompares++; $display("FAIL basic_kept got n2=%h op=%0d want 0003/0", num2, operation); end
  endtask

  task automatic test_digit_entry();
    clrk();
    dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4); dig(4'd5);
    vectors++; if (num1 !== 16'h1234) begin miscompares++; $display("FAIL saturate got %h want 1234", num1); end
    clrk(); dig(4'd0); dig(4'd0);
    vectors++; if (num1 !== 16'h0000 || state !== 3'd0) begin miscompares++; $display("FAIL zeros got n1=%h st=%0d want 0000/0", num1, state); end
    // Leading zeros uncounted: four more real digits still fit.
    dig(4'd1); dig(4'd2); dig(4'd3); dig(4'd4);
    vectors++; if (num1 !== 16'h1234) begin miscompares++; $display("FAIL lead_zero got %h want 1234", num1); end
    clrk(); dig(4'd10); dig(4'd6);
    vectors++; if (num1 !== 16'h0006) begin miscompares++; $display("FAIL bad_digit got %h want 0006", num1); end
    key(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, OP_MUL);
    vectors++; if (state !== 3'd1 || operation !== OP_MUL || num1 !== 16'h0006) begin miscompares++; $display("FAIL priority got st=%0d op=%0d n1=%h want 1/2/0006", state, operation, num1); end
    eqk();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL eq_in_op got %0d want 1", state); end
  endtask

  task automatic test_chain();
    clrk(); dig(4'd7); opk(OP_ADD); dig(4'd8); opk(OP_SUB);
    vectors++; if (state !== 3'd3 || alu_req !== 1'b1 || num1 !== 16'h0007 || num2 !== 16'h0008 || operation !== OP_ADD) begin miscompares++; $display("FAIL chain_wait got st=%0d req=%b n1=%h n2=%h op=%0d want 3/1/0007/0008/0", state, alu_req, num1, num2, operation); end
    dig(4'd9);
    vectors++; if (num2 !== 16'h0008 || state !== 3'd3) begin miscompares++; $display("FAIL chain_key got n2=%h st=%0d want 0008/3", num2, state); end
    ack(16'h0015, 1'b0);
    vectors++; if (num1 !== 16'h0015 || operation !== OP_SUB || num2 !== 16'h0 || state !== 3'd1) begin miscompares++; $display("FAIL chain_done got n1=%h op=%0d n2=%h st=%0d want 0015/1/0000/1", num1, operation, num2, state); end
  endtask

  task automatic test_repeat_eq();
    clrk(); dig(4'd2); opk(OP_ADD); dig(4'd3); eqk();
    ack(16'h0005, 1'b0);
    vectors++; if (num1 !== 16'h0005 || state !== 3'd5) begin miscompares++; $display("FAIL rep_first got n1=%h st=%0d want 0005/5", num1, state); end
    eqk();
    vectors++; if (state !== 3'd4 || alu_req !== 1'b1 || num2 !== 16'h0003 || num1 !== 16'h0005) begin miscompares++; $display("FAIL rep_req got st=%0d req=%b n2=%h n1=%h want 4/1/0003/0005", state, alu_req, num2, num1); end
    ack(16'h0008, 1'b0);
    vectors++; if (num1 !== 16'h0008 || state !== 3'd5) begin miscompares++; $display("FAIL rep_second got n1=%h st=%0d want 0008/5", num1, state); end
    dig(4'd9);
    vectors++; if (num1 !== 16'h0009 || num2 !== 16'h0 || state !== 3'd0) begin miscompares++; $display("FAIL res_num got n1=%h n2=%h st=%0d want 0009/0000/0", num1, num2, state); end
    ack(16'hAAAA, 1'b0);
    vectors++; if (num1 !== 16'h0009 || state !== 3'd0) begin miscompares++; $display("FAIL idle_ack got n1=%h st=%0d want 0009/0", num1, state); end
  endtask

  task automatic test_error();
    clrk(); dig(4'd1); opk(OP_DIV); dig(4'd2); eqk();
    ack(16'h0000, 1'b1);
    vectors++; if (error !== 1'b1 || state !== 3'd6 || num1 !== 16'h0001 || alu_req !== 1'b0) begin miscompares++; $display("FAIL err_enter got err=%b st=%0d n1=%h req=%b want 1/6/0001/0", error, state, num1, alu_req); end
    dig(4'd5); eqk();
    vectors++; if (state !== 3'd6 || num1 !== 16'h0001) begin miscompares++; $display("FAIL err_hold got st=%0d n1=%h want 6/0001", state, num1); end
    clrk();
    vectors++; if (state !== 3'd0 || error !== 1'b0 || num1 !== 16'h0 || num2 !== 16'h0 || operation !== 2'd0 || disp_val !== 16'h0) begin miscompares++; $display("FAIL err_clr got st=%0d err=%b n1=%h n2=%h op=%0d disp=%h want all 0", state, error, num1, num2, operation, disp_val); end
  endtask

  task automatic test_clr_in_wait();
    clrk(); dig(4'd4); opk(OP_ADD); dig(4'd5); eqk();
    vectors++; if (alu_req !== 1'b1) begin miscompares++; $display("FAIL wait_req got %b want 1", alu_req); end
    clrk();
    vectors++; if (alu_req !== 1'b0 || state !== 3'd0 || num1 !== 16'h0) begin miscompares++; $display("FAIL wait_clr got req=%b st=%0d n1=%h want 0/0/0000", alu_req, state, num1); end
    ack(16'h0099, 1'b0);
    vectors++; if (num1 !== 16'h0 || state !== 3'd0 || error !== 1'b0) begin miscompares++; $display("FAIL late_ack got n1=%h st=%0d err=%b want 0000/0/0", num1, state, error); end
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_is_num = 1'b0; key_is_op = 1'b0; key_is_eq = 1'b0;
    key_is_clr = 1'b0; key_is_bs = 1'b0; key_num = 4'd0; key_op = 2'd0;
    alu_ack = 1'b0; alu_err = 1'b0; alu_result = 16'h0;
    test_reset();
    test_basic_calc();
    test_digit_entry();
    test_chain();
    test_repeat_eq();
    test_error();
    test_clr_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
